buffer_skid_wb: RTL and testbench
=================================

BUFFER_SKID_WB -- requirements
Module: buffer_skid_wb

Interface
REQ-001 Parameter DATA_W, default 32: width of read-data and ALU-result payload fields.
REQ-002 Parameter REG_W, default 5: width of destination-register field.
REQ-003 Parameter CTRL_W, default 2: width of write-back control field (regWrite, memToReg).
REQ-004 Parameter CNT_W, default 8: width of stall-cycle counter.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port flush, input, 1: discard all held entries.
REQ-008 Port in_valid, input, 1: upstream beat present.
REQ-009 Port in_ready, output, 1: buffer can accept a beat this cycle.
REQ-010 Port inReadData, input, DATA_W: memory read data.
REQ-011 Port inOutAlu, input, DATA_W: ALU result.
REQ-012 Port inMux5b, input, REG_W: destination register.
REQ-013 Port inCtrl, input, CTRL_W: write-back control.
REQ-014 Port out_valid, output, 1: head entry present.
REQ-015 Port out_ready, input, 1: downstream consumes head this cycle.
REQ-016 Ports outReadData/outOutAlu/outMux5b/outCtrl, output, DATA_W/DATA_W/REG_W/CTRL_W: head-entry payload.
REQ-017 Port occupancy, output, 2: entries held (0..2).
REQ-018 Port stallCount, output, CNT_W: saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-019 Two-entry skid buffer: head register drives outputs; skid register holds second entry; states EMPTY, ONE, FULL.
REQ-020 accept = in_valid & in_ready & !flush; pop = out_valid & out_ready.
REQ-021 in_ready SHALL be a registered function of state: 1 in EMPTY/ONE, 0 in FULL; no combinational path from out_ready.
REQ-022 EMPTY: accept -> ONE, head <= input; else stay.
REQ-023 ONE: accept & pop -> ONE, head <= input; accept & !pop -> FULL, skid <= input; !accept & pop -> EMPTY; else stay.
REQ-024 FULL: pop -> ONE, head <= skid; else stay; input ignored.
REQ-025 Order SHALL be preserved; no beat duplicated or dropped except by flush/rst.
REQ-026 Latency: beat accepted at edge N is visible on outputs after edge N, i.e. cycle N+1, when buffer was EMPTY or popping.
REQ-027 Payload outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 out_valid = (state != EMPTY); occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-029 flush SHALL, at next edge, move to EMPTY, discard any input beat offered that cycle, and discard any beat popped that cycle from buffer state (the pop still counts downstream).
REQ-030 Payload registers not cleared on flush; values undefined-but-stable while out_valid=0.
REQ-031 stallCount increments by 1 each cycle out_valid & !out_ready, saturates at 2^CNT_W-1, unaffected by flush.

Reset
REQ-032 rst=1 at edge: state EMPTY, in_ready=1, out_valid=0, occupancy=0, stallCount=0, all payload outputs 0.
REQ-033 rst SHALL override flush, in_valid and out_ready in the same cycle; mid-transfer beats are dropped.

Verification
REQ-034 Pass-through: out_ready=1, beats A=0x11,B=0x22 on consecutive cycles -> outOutAlu shows 0x11 then 0x22 one cycle after each, occupancy stays 1.
REQ-035 Backpressure: out_ready=0, offer A,B,C -> A,B accepted, in_ready=0 in FULL, C held upstream; out_ready=1 -> A,B,C emerge in order, none lost.
REQ-036 Simultaneous accept/pop in ONE -> head replaced by new beat, state ONE, occupancy 1.
REQ-037 Flush in FULL with in_valid=1 -> next cycle out_valid=0, occupancy 0, in_ready=1, offered beat absent from output.
REQ-038 CNT_W=2, out_valid=1, out_ready=0 for 5 cycles -> stallCount 1,2,3,3,3.
REQ-039 rst asserted while FULL -> next cycle all outputs per REQ-032; subsequent beat D appears after one cycle.

Source files
------------

// File: rtl/buffer_skid_wb.sv
// Two-entry skid buffer for the write-back stage payload (read data, ALU result,
// destination register, control). in_ready depends only on registered state.
module buffer_skid_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] inReadData,
    input  logic [DATA_W-1:0] inOutAlu,
    input  logic [REG_W-1:0]  inMux5b,
    input  logic [CTRL_W-1:0] inCtrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] outReadData,
    output logic [DATA_W-1:0] outOutAlu,
    output logic [REG_W-1:0]  outMux5b,
    output logic [CTRL_W-1:0] outCtrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stallCount
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              pop;
    logic              load_head_in;
    logic              load_head_skid;
    logic              load_skid;

    logic [DATA_W-1:0] skid_read_data;
    logic [DATA_W-1:0] skid_out_alu;
    logic [REG_W-1:0]  skid_mux5b;
    logic [CTRL_W-1:0] skid_ctrl;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    // Next state and payload-load selects; flush wins over any transfer.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt      = ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= EMPTY;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            occupancy      <= 2'd0;
            stallCount     <= '0;
            outReadData    <= '0;
            outOutAlu      <= '0;
            outMux5b       <= '0;
            outCtrl        <= '0;
            skid_read_data <= '0;
            skid_out_alu   <= '0;
            skid_mux5b     <= '0;
            skid_ctrl      <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
            occupancy <= (state_nxt == FULL) ? 2'd2 : (state_nxt == ONE) ? 2'd1 : 2'd0;

            if (out_valid && !out_ready && stallCount != CNT_MAX)
                stallCount <= stallCount + CNT_W'(1);

            if (load_head_in) begin
                outReadData <= inReadData;
                outOutAlu   <= inOutAlu;
                outMux5b    <= inMux5b;
                outCtrl     <= inCtrl;
            end else if (load_head_skid) begin
                outReadData <= skid_read_data;
                outOutAlu   <= skid_out_alu;
                outMux5b    <= skid_mux5b;
                outCtrl     <= skid_ctrl;
            end

            if (load_skid) begin
                skid_read_data <= inReadData;
                skid_out_alu   <= inOutAlu;
                skid_mux5b     <= inMux5b;
                skid_ctrl      <= inCtrl;
            end
        end
    end

endmodule

// File: tb/tb_buffer_skid_wb.sv
// Directed + random bench for buffer_skid_wb: a queue scoreboard predicts the
// head entry, occupancy, handshakes and the saturating stall counter.
module tb_buffer_skid_wb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 2;
    localparam int unsigned CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] inReadData;
    logic [DATA_W-1:0] inOutAlu;
    logic [REG_W-1:0]  inMux5b;
    logic [CTRL_W-1:0] inCtrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] outReadData;
    logic [DATA_W-1:0] outOutAlu;
    logic [REG_W-1:0]  outMux5b;
    logic [CTRL_W-1:0] outCtrl;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stallCount;

    buffer_skid_wb #(
        .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .inReadData(inReadData), .inOutAlu(inOutAlu), .inMux5b(inMux5b), .inCtrl(inCtrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .outReadData(outReadData), .outOutAlu(outOutAlu), .outMux5b(outMux5b), .outCtrl(outCtrl),
        .occupancy(occupancy), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    logic [7:0]  q[$];
    int unsigned sc_exp   = 0;
    bit          exp_zero = 1'b0;

    function automatic logic [DATA_W-1:0] rd_of(input logic [7:0] v);
        return {16'hA5C3, v, ~v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the DUT against the model state produced by the previous edge.
    task automatic check_outputs();
        chk("in_ready",   64'(in_ready),   64'(q.size() < 2));
        chk("out_valid",  64'(out_valid),  64'(q.size() != 0));
        chk("occupancy",  64'(occupancy),  64'(q.size()));
        chk("stallCount", 64'(stallCount), 64'(sc_exp));
        if (q.size() != 0) begin
            chk("outOutAlu",   64'(outOutAlu),   64'(DATA_W'(q[0])));
            chk("outReadData", 64'(outReadData), 64'(rd_of(q[0])));
            chk("outMux5b",    64'(outMux5b),    64'(REG_W'(q[0])));
            chk("outCtrl",     64'(outCtrl),     64'(CTRL_W'(q[0] >> 5)));
        end
        if (exp_zero) begin
            chk("rst_payload", 64'({outReadData, outOutAlu} | 64'({outMux5b, outCtrl})), 64'd0);
        end
    endtask

    task automatic step(input bit r, input bit iv, input logic [7:0] v, input bit ordy, input bit fl);
        bit acc;
        bit pp;
        @(negedge clk);
        check_outputs();
        rst        = r;
        in_valid   = iv;
        inOutAlu   = DATA_W'(v);
        inReadData = rd_of(v);
        inMux5b    = REG_W'(v);
        inCtrl     = CTRL_W'(v >> 5);
        out_ready  = ordy;
        flush      = fl;
        if (r) begin
            q.delete();
            sc_exp   = 0;
            exp_zero = 1'b1;
        end else begin
            exp_zero = 1'b0;
            pp  = (q.size() != 0) && ordy;
            acc = iv && (q.size() < 2) && !fl;
            if (q.size() != 0 && !ordy && sc_exp < 3) sc_exp++;
            if (fl) q.delete();
            else begin
                if (pp)  void'(q.pop_front());
                if (acc) q.push_back(v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inReadData = '0; inOutAlu = '0; inMux5b = '0; inCtrl = '0;
        @(posedge clk);
        step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'hEE, 1, 1);

        // pass-through
        step(0, 1, 8'h11, 1, 0);
        step(0, 1, 8'h22, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);

        // backpressure: C must wait upstream until space opens
        step(0, 1, 8'h2A, 0, 0);
        step(0, 1, 8'h2B, 0, 0);
        step(0, 1, 8'h2C, 0, 0);
        step(0, 1, 8'h2C, 0, 0);
        step(0, 1, 8'h2C, 1, 0);
        step(0, 1, 8'h2C, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);

        // simultaneous accept and pop in ONE
        step(0, 1, 8'h40, 0, 0);
        step(0, 1, 8'h41, 1, 0);
        step(0, 0, 8'h00, 1, 0);

        // flush while FULL with a beat offered
        step(0, 1, 8'h50, 0, 0);
        step(0, 1, 8'h51, 0, 0);
        step(0, 1, 8'h52, 1, 1);
        step(0, 0, 8'h00, 1, 0);

        // stall counter saturation from reset
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'h60, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);

        // reset while FULL, then a fresh beat
        step(0, 1, 8'h70, 0, 0);
        step(0, 1, 8'h71, 0, 0);
        step(1, 1, 8'h72, 1, 1);
        step(0, 1, 8'h0D, 1, 0);
        step(0, 0, 8'h00, 1, 0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(0, 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        @(negedge clk);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
